// File: rtl/multi_channel_counter.sv
// Bank of independent up/down counters with per-channel load, global clear,
// wrap or saturate overflow, terminal-count pulses and a one-entry snapshot readout.
module multi_channel_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP     = 1,
  parameter int SATURATE = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_value,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       tc_pulse,
  input  logic                      rd_req_valid,
  input  logic [CW-1:0]             rd_req_chan,
  output logic                      rd_req_ready,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  input  logic                      rd_ready
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  logic [WIDTH-1:0]    r_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_tc;
  logic                r_rd_valid;
  logic [WIDTH-1:0]    r_rd_data;

  logic [WIDTH:0]      w_up   [CHANNELS];
  logic [WIDTH:0]      w_dn   [CHANNELS];
  logic [WIDTH-1:0]    w_next [CHANNELS];
  logic [CHANNELS-1:0] w_tc;
  logic [WIDTH-1:0]    w_rd_snap;
  logic                w_rd_accept;

  // The extra MSB of w_up/w_dn is the exact carry/borrow of the step.
  always_comb begin
    w_tc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_up[i]   = {1'b0, r_cnt[i]} + STEP_X;
      w_dn[i]   = {1'b0, r_cnt[i]} - STEP_X;
      w_next[i] = r_cnt[i];
      if (!dir[i]) begin
        if (SATURATE == 0) begin
          w_next[i] = w_up[i][WIDTH-1:0];
          w_tc[i]   = w_up[i][WIDTH];
        end else if (w_up[i][WIDTH] || (w_up[i][WIDTH-1:0] == MAX_V)) begin
          w_next[i] = MAX_V;
          w_tc[i]   = (r_cnt[i] != MAX_V);
        end else begin
          w_next[i] = w_up[i][WIDTH-1:0];
        end
      end else begin
        if (SATURATE == 0) begin
          w_next[i] = w_dn[i][WIDTH-1:0];
          w_tc[i]   = w_dn[i][WIDTH];
        end else if (w_dn[i][WIDTH] || (w_dn[i][WIDTH-1:0] == '0)) begin
          w_next[i] = '0;
          w_tc[i]   = (r_cnt[i] != '0);
        end else begin
          w_next[i] = w_dn[i][WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_tc <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_tc[i] <= 1'b0;
        if (clear) begin
          r_cnt[i] <= '0;
        end else if (load[i]) begin
          r_cnt[i] <= load_value;
        end else if (en[i]) begin
          r_cnt[i] <= w_next[i];
          r_tc[i]  <= w_tc[i];
        end
      end
    end
  end

  // Unmatched channel numbers fall through to zero.
  always_comb begin
    w_rd_snap = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_req_chan == CW'(i)) w_rd_snap = r_cnt[i];
    end
  end

  assign rd_req_ready = !r_rd_valid || rd_ready;
  assign w_rd_accept  = rd_req_valid && rd_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_rd_accept) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_snap;
    end else if (rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign count_out[g*WIDTH +: WIDTH] = r_cnt[g];
  end

  assign tc_pulse = r_tc;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench: a wrap-mode 4-channel bank plus a saturating 5-channel,
// STEP=3 bank sharing the count stimulus.
module tb_multi_channel_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  en, dir, load;
  logic [7:0]  load_value;
  logic [31:0] count_out;
  logic [3:0]  tc_pulse;
  logic        rd_req_valid;
  logic [1:0]  rd_req_chan;
  logic        rd_req_ready, rd_valid, rd_ready;
  logic [7:0]  rd_data;

  logic [4:0]  s_en, s_dir, s_load;
  logic [39:0] s_count_out;
  logic [4:0]  s_tc_pulse;
  logic        s_rd_req_valid, s_rd_req_ready, s_rd_valid, s_rd_ready;
  logic [2:0]  s_rd_req_chan;
  logic [7:0]  s_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign s_en   = {1'b0, en};
  assign s_dir  = {1'b0, dir};
  assign s_load = {1'b0, load};

  multi_channel_counter u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .count_out(count_out), .tc_pulse(tc_pulse),
    .rd_req_valid(rd_req_valid), .rd_req_chan(rd_req_chan), .rd_req_ready(rd_req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
  );

  multi_channel_counter #(.WIDTH(8), .CHANNELS(5), .STEP(3), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(s_en), .dir(s_dir), .load(s_load),
    .load_value(load_value), .count_out(s_count_out), .tc_pulse(s_tc_pulse),
    .rd_req_valid(s_rd_req_valid), .rd_req_chan(s_rd_req_chan), .rd_req_ready(s_rd_req_ready),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_ready(s_rd_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sat_seq [4];
    logic       sat_tc  [4];
    sat_seq = '{8'd2, 8'd0, 8'd0, 8'd0};
    sat_tc  = '{1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; clear = 1'b0; en = '0; dir = '0; load = '0; load_value = '0;
    rd_req_valid = 1'b0; rd_req_chan = '0; rd_ready = 1'b0;
    s_rd_req_valid = 1'b0; s_rd_req_chan = '0; s_rd_ready = 1'b1;

    #1;
    check_eq("rst_count", count_out, 32'h0);
    check_eq("rst_req_ready", rd_req_ready, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_count", count_out, 32'h0);
    check_eq("idle_tc", tc_pulse, 4'h0);
    check_eq("idle_rd_valid", rd_valid, 1'b0);
    check_eq("idle_req_ready", rd_req_ready, 1'b1);
    check_eq("idle_sat_count", s_count_out, 40'h0);

    // wrap up through 0xFF -> 0x00
    load = 4'b0001; load_value = 8'hFE;
    tick();
    check_eq("wrap_load", count_out[7:0], 8'hFE);
    check_eq("wrap_load_tc", tc_pulse, 4'h0);
    load = '0; en = 4'b0001; dir = '0;
    tick();
    check_eq("wrap_ff", count_out[7:0], 8'hFF);
    check_eq("wrap_ff_tc", tc_pulse, 4'h0);
    tick();
    check_eq("wrap_00", count_out[7:0], 8'h00);
    check_eq("wrap_00_tc", tc_pulse, 4'h1);
    tick();
    check_eq("wrap_01", count_out[7:0], 8'h01);
    check_eq("wrap_01_tc", tc_pulse, 4'h0);
    en = '0;

    // saturate down by 3 from 5
    load = 4'b0100; load_value = 8'd5;
    tick();
    check_eq("sat_load", s_count_out[23:16], 8'd5);
    load = '0; en = 4'b0100; dir = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("sat_dn_%0d", k), s_count_out[23:16], sat_seq[k]);
      check_eq($sformatf("sat_tc_%0d", k), s_tc_pulse[2], sat_tc[k]);
    end
    check_eq("wrap_dn_ch2", count_out[23:16], 8'd1);
    en = '0; dir = '0;

    // clear beats load beats enable
    clear = 1'b1; load = 4'b0010; en = 4'b0010; load_value = 8'h33;
    tick();
    check_eq("prio_clear", count_out, 32'h0);
    check_eq("prio_clear_tc", tc_pulse, 4'h0);
    clear = 1'b0; load_value = 8'h40;
    tick();
    check_eq("prio_load", count_out[15:8], 8'h40);
    check_eq("prio_load_tc", tc_pulse, 4'h0);
    load = '0; en = '0;

    // readout under backpressure
    load = 4'b1000; load_value = 8'd7;
    tick();
    load = '0; en = 4'b1000; dir = '0;
    rd_req_valid = 1'b1; rd_req_chan = 2'd3; rd_ready = 1'b0;
    #1;
    check_eq("bp_ready_pre", rd_req_ready, 1'b1);
    tick();
    rd_req_valid = 1'b0;
    check_eq("bp_acc_valid", rd_valid, 1'b1);
    check_eq("bp_acc_data", rd_data, 8'd7);
    check_eq("bp_acc_count", count_out[31:24], 8'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("bp_hold_data_%0d", k), rd_data, 8'd7);
      check_eq($sformatf("bp_hold_valid_%0d", k), rd_valid, 1'b1);
      check_eq($sformatf("bp_hold_ready_%0d", k), rd_req_ready, 1'b0);
    end
    check_eq("bp_count", count_out[31:24], 8'h0B);
    rd_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", rd_req_ready, 1'b1);
    tick();
    check_eq("bp_drained", rd_valid, 1'b0);
    check_eq("sat_ch3", s_count_out[31:24], 8'h16);

    // back-to-back reads while ch0/ch2 keep counting
    en = 4'b0101;
    rd_req_valid = 1'b1; rd_req_chan = 2'd0;
    s_rd_req_valid = 1'b1; s_rd_req_chan = 3'd3;
    tick();
    check_eq("b2b_v0", rd_valid, 1'b1);
    check_eq("b2b_d0", rd_data, 8'h00);
    check_eq("b2b_ch0", count_out[7:0], 8'h01);
    check_eq("oor_pre_data", s_rd_data, 8'h16);
    rd_req_chan = 2'd1; s_rd_req_chan = 3'd5;
    tick();
    check_eq("b2b_v1", rd_valid, 1'b1);
    check_eq("b2b_d1", rd_data, 8'h40);
    check_eq("oor_valid", s_rd_valid, 1'b1);
    check_eq("oor_data", s_rd_data, 8'h00);
    s_rd_req_valid = 1'b0;
    rd_req_chan = 2'd2;
    tick();
    check_eq("b2b_v2", rd_valid, 1'b1);
    check_eq("b2b_d2", rd_data, 8'h02);
    check_eq("b2b_ch2", count_out[23:16], 8'h03);
    rd_req_chan = 2'd3;
    tick();
    check_eq("b2b_v3", rd_valid, 1'b1);
    check_eq("b2b_d3", rd_data, 8'h0C);
    rd_req_valid = 1'b0; en = '0;
    tick();
    check_eq("b2b_end", rd_valid, 1'b0);

    // reset while a read is pending
    rd_ready = 1'b0; rd_req_valid = 1'b1; rd_req_chan = 2'd1;
    tick();
    rd_req_valid = 1'b0;
    check_eq("mid_valid", rd_valid, 1'b1);
    check_eq("mid_data", rd_data, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", rd_valid, 1'b0);
    check_eq("mid_rst_data", rd_data, 8'h00);
    check_eq("mid_rst_count", count_out, 32'h0);
    check_eq("mid_rst_ready", rd_req_ready, 1'b1);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
